hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port OPCODE_ID  in  7  opcode of instruction in ID.
REQ-004 SHALL have ports RS1_ID, RS2_ID  in  5 each  source register indices in ID.
REQ-005 SHALL have port RD_EX  in  5  destination register of instruction in EX.
REQ-006 SHALL have port MemRead_EX  in  1  instruction in EX is a load.
REQ-007 SHALL have port BRANCH_TAKEN_EX  in  1  branch/jump in EX redirects PC.
REQ-008 SHALL have port MEM_BUSY  in  1  data memory not ready; pipeline must hold.
REQ-009 SHALL have ports PC_WRITE, IF_ID_WRITE  out  1 each  enables for PC and IF/ID registers.
REQ-010 SHALL have ports IF_ID_FLUSH, ID_EX_BUBBLE  out  1 each  squash IF/ID; load NOP into ID/EX.
REQ-011 SHALL have port PIPE_FREEZE  out  1  hold ID/EX, EX/MEM, MEM/WB registers.
REQ-012 SHALL have port HALTED  out  1  core stopped after SYSTEM instruction.
REQ-013 SHALL have port STATE  out  2  FSM state: RUN=0, DRAIN=1, HALT=2; 3 unused.
REQ-014 SHALL have ports STALL_CNT, FLUSH_CNT  out  16 each  saturating event counters.

Function
REQ-015 SHALL produce PC_WRITE..PIPE_FREEZE combinationally from STATE and inputs (same-cycle); counters and STATE registered.
REQ-016 SHALL define rs1-used = OPCODE_ID not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1110011 SYSTEM}; rs2-used = OPCODE_ID in {0110011, 0100011, 1100011}.
REQ-017 SHALL define load-use = MemRead_EX & RD_EX!=0 & ((rs1-used & RD_EX==RS1_ID) | (rs2-used & RD_EX==RS2_ID)).
REQ-018 RUN, default: PC_WRITE=1, IF_ID_WRITE=1, all other controls 0.
REQ-019 RUN priority, highest first: MEM_BUSY, BRANCH_TAKEN_EX, SYSTEM in ID (OPCODE_ID=1110011), load-use.
REQ-020 RUN+MEM_BUSY: PC_WRITE=0, IF_ID_WRITE=0, PIPE_FREEZE=1, FLUSH/BUBBLE=0; stay RUN.
REQ-021 RUN+BRANCH_TAKEN_EX: PC_WRITE=1, IF_ID_WRITE=1, IF_ID_FLUSH=1, ID_EX_BUBBLE=1; stay RUN; pending SYSTEM or load-use in ID ignored (squashed).
REQ-022 RUN+SYSTEM: PC_WRITE=0, IF_ID_WRITE=0, ID_EX_BUBBLE=1; next state DRAIN, drain counter loaded with 3.
REQ-023 RUN+load-use: PC_WRITE=0, IF_ID_WRITE=0, ID_EX_BUBBLE=1 for exactly that cycle; stay RUN.
REQ-024 DRAIN: PC_WRITE=0, IF_ID_WRITE=0, ID_EX_BUBBLE=1; BRANCH_TAKEN_EX and load-use ignored.
REQ-025 DRAIN+MEM_BUSY: additionally PIPE_FREEZE=1, ID_EX_BUBBLE=0, drain counter holds.
REQ-026 DRAIN, MEM_BUSY=0: counter decrements; when counter is 1 at the edge, next state HALT.
REQ-027 HALT: PC_WRITE=0, IF_ID_WRITE=0, ID_EX_BUBBLE=1, PIPE_FREEZE=1, HALTED=1; exit only via reset; all inputs ignored.
REQ-028 STALL_CNT SHALL increment by 1 on each edge where load-use stall (REQ-023) or MEM_BUSY freeze (REQ-020/025) was asserted; saturates at 0xFFFF.
REQ-029 FLUSH_CNT SHALL increment by 1 on each edge where IF_ID_FLUSH=1; saturates at 0xFFFF.
REQ-030 Counters SHALL not change in HALT.
REQ-031 STATE encoding 3 SHALL transition to RUN at next edge with RUN outputs.

Reset
REQ-032 rst_n=0 at rising edge SHALL force STATE=RUN, drain counter=0, STALL_CNT=0, FLUSH_CNT=0; HALTED=0.
REQ-033 While rst_n=0, outputs SHALL follow RUN rules from current inputs after first reset edge; reset in DRAIN or HALT returns to RUN next edge.

Verification
REQ-034 MemRead_EX=1, RD_EX=5, OPCODE_ID=0110011, RS2_ID=5 -> PC_WRITE=0, IF_ID_WRITE=0, ID_EX_BUBBLE=1 one cycle; STALL_CNT 0->1.
REQ-035 Same as REQ-034 with RD_EX=0, or OPCODE_ID=0110111 with RS1_ID=5 -> no stall, STALL_CNT unchanged.
REQ-036 BRANCH_TAKEN_EX=1 with load-use true -> IF_ID_FLUSH=1, ID_EX_BUBBLE=1, PC_WRITE=1; FLUSH_CNT +1, STALL_CNT unchanged.
REQ-037 OPCODE_ID=1110011 in RUN -> STATE=1 for 3 cycles, then STATE=2, HALTED=1; with MEM_BUSY=1 for 2 cycles mid-drain -> HALT reached 2 cycles later, STALL_CNT +2.
REQ-038 MEM_BUSY=1 held 70000 cycles -> PIPE_FREEZE=1 throughout, STALL_CNT=0xFFFF, no wrap.
REQ-039 rst_n=0 one edge while HALTED=1 -> STATE=0, HALTED=0, counters 0, PC_WRITE=1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard and halt sequencing for a 5-stage core.
//
// Decides each cycle whether the front end advances, whether IF/ID is
// squashed, whether a bubble enters ID/EX and whether the back end freezes.
// A SYSTEM instruction in ID starts a three-cycle drain, then the core halts
// until reset. Stall and flush events are tallied in saturating counters.
//
// Ports
//   clk             : single clock, rising-edge
//   rst_n           : synchronous active-low reset
//   OPCODE_ID       : [6:0] opcode of instruction in ID
//   RS1_ID, RS2_ID  : [4:0] source register indices in ID
//   RD_EX           : [4:0] destination register of instruction in EX
//   MemRead_EX      : instruction in EX is a load
//   BRANCH_TAKEN_EX : branch/jump in EX redirects the PC
//   MEM_BUSY        : data memory not ready, pipeline must hold
//   PC_WRITE        : PC register enable
//   IF_ID_WRITE     : IF/ID register enable
//   IF_ID_FLUSH     : squash IF/ID contents
//   ID_EX_BUBBLE    : load a NOP into ID/EX
//   PIPE_FREEZE     : hold ID/EX, EX/MEM, MEM/WB
//   HALTED          : core stopped after SYSTEM instruction
//   STATE           : [1:0] RUN=0, DRAIN=1, HALT=2
//   STALL_CNT       : [15:0] saturating stall-event count
//   FLUSH_CNT       : [15:0] saturating flush-event count
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  OPCODE_ID,
  input  logic [4:0]  RS1_ID,
  input  logic [4:0]  RS2_ID,
  input  logic [4:0]  RD_EX,
  input  logic        MemRead_EX,
  input  logic        BRANCH_TAKEN_EX,
  input  logic        MEM_BUSY,
  output logic        PC_WRITE,
  output logic        IF_ID_WRITE,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_BUBBLE,
  output logic        PIPE_FREEZE,
  output logic        HALTED,
  output logic [1:0]  STATE,
  output logic [15:0] STALL_CNT,
  output logic [15:0] FLUSH_CNT
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALT   = 2'd2,
    UNUSED = 2'd3
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t      state;
  logic [1:0]  drain_cnt;
  logic        rs1_used;
  logic        rs2_used;
  logic        load_use;
  logic        is_system;
  logic        stall_ev;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign rs1_used  = !(OPCODE_ID inside {OP_LUI, OP_AUIPC, OP_JAL, OP_SYSTEM});
  assign rs2_used  = OPCODE_ID inside {OP_OP, OP_STORE, OP_BRANCH};
  assign load_use  = MemRead_EX && (RD_EX != 5'd0) &&
                     ((rs1_used && (RD_EX == RS1_ID)) ||
                      (rs2_used && (RD_EX == RS2_ID)));
  assign is_system = (OPCODE_ID == OP_SYSTEM);

  assign STATE  = state;
  assign HALTED = (state == HALT);

  // Control decode: same-cycle response to the current state and inputs.
  always_comb begin
    PC_WRITE     = 1'b1;
    IF_ID_WRITE  = 1'b1;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_BUBBLE = 1'b0;
    PIPE_FREEZE  = 1'b0;
    stall_ev     = 1'b0;
    case (state)
      DRAIN: begin
        PC_WRITE    = 1'b0;
        IF_ID_WRITE = 1'b0;
        if (MEM_BUSY) begin
          PIPE_FREEZE = 1'b1;
          stall_ev    = 1'b1;
        end else begin
          ID_EX_BUBBLE = 1'b1;
        end
      end
      HALT: begin
        PC_WRITE     = 1'b0;
        IF_ID_WRITE  = 1'b0;
        ID_EX_BUBBLE = 1'b1;
        PIPE_FREEZE  = 1'b1;
      end
      default: begin
        // RUN and the unused encoding share the RUN priority chain.
        if (MEM_BUSY) begin
          PC_WRITE    = 1'b0;
          IF_ID_WRITE = 1'b0;
          PIPE_FREEZE = 1'b1;
          stall_ev    = 1'b1;
        end else if (BRANCH_TAKEN_EX) begin
          // The ID instruction is squashed, so its hazards do not matter.
          IF_ID_FLUSH  = 1'b1;
          ID_EX_BUBBLE = 1'b1;
        end else if (is_system) begin
          PC_WRITE     = 1'b0;
          IF_ID_WRITE  = 1'b0;
          ID_EX_BUBBLE = 1'b1;
        end else if (load_use) begin
          PC_WRITE     = 1'b0;
          IF_ID_WRITE  = 1'b0;
          ID_EX_BUBBLE = 1'b1;
          stall_ev     = 1'b1;
        end
      end
    endcase
  end

  // State, drain counter and event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
      STALL_CNT <= 16'd0;
      FLUSH_CNT <= 16'd0;
    end else begin
      case (state)
        RUN: begin
          if (!MEM_BUSY && !BRANCH_TAKEN_EX && is_system) begin
            state     <= DRAIN;
            drain_cnt <= 2'd3;
          end
        end
        DRAIN: begin
          if (!MEM_BUSY) begin
            if (drain_cnt <= 2'd1) state <= HALT;
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
      if (stall_ev)    STALL_CNT <= sat_inc(STALL_CNT);
      if (IF_ID_FLUSH) FLUSH_CNT <= sat_inc(FLUSH_CNT);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Inputs change on the falling edge and
// outputs are sampled 2 ns later; the following rising edge commits state.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [6:0]  OPCODE_ID;
  logic [4:0]  RS1_ID, RS2_ID, RD_EX;
  logic        MemRead_EX, BRANCH_TAKEN_EX, MEM_BUSY;
  logic        PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE, PIPE_FREEZE, HALTED;
  logic [1:0]  STATE;
  logic [15:0] STALL_CNT, FLUSH_CNT;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .OPCODE_ID(OPCODE_ID), .RS1_ID(RS1_ID),
    .RS2_ID(RS2_ID), .RD_EX(RD_EX), .MemRead_EX(MemRead_EX),
    .BRANCH_TAKEN_EX(BRANCH_TAKEN_EX), .MEM_BUSY(MEM_BUSY),
    .PC_WRITE(PC_WRITE), .IF_ID_WRITE(IF_ID_WRITE), .IF_ID_FLUSH(IF_ID_FLUSH),
    .ID_EX_BUBBLE(ID_EX_BUBBLE), .PIPE_FREEZE(PIPE_FREEZE), .HALTED(HALTED),
    .STATE(STATE), .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  // {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE, PIPE_FREEZE, HALTED}
  localparam logic [5:0] C_RUN  = 6'b110000;
  localparam logic [5:0] C_BUSY = 6'b000010;
  localparam logic [5:0] C_BR   = 6'b111100;
  localparam logic [5:0] C_BUB  = 6'b000100;
  localparam logic [5:0] C_HALT = 6'b000111;

  typedef struct packed {
    logic       rstn;
    logic [6:0] op;
    logic [4:0] rs1, rs2, rd;
    logic       mr, br, mb;
    logic [5:0] ctl;
    logic [1:0] st;
    logic       sev, fev;
  } vec_t;

  typedef struct packed {
    logic [5:0]  ctl;
    logic [1:0]  st;
    logic [15:0] sc, fc;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] m_sc = 16'd0;
  logic [15:0] m_fc = 16'd0;

  function automatic vec_t V(logic rstn, logic [6:0] op, logic [4:0] rs1, logic [4:0] rs2,
                             logic [4:0] rd, logic mr, logic br, logic mb,
                             logic [5:0] ctl, logic [1:0] st, logic sev, logic fev);
    return '{rstn:rstn, op:op, rs1:rs1, rs2:rs2, rd:rd, mr:mr, br:br, mb:mb,
             ctl:ctl, st:st, sev:sev, fev:fev};
  endfunction

  // Idle ADDI x?,x1: reads rs1 only, nothing loading in EX.
  function automatic vec_t IDLE(logic [5:0] ctl, logic [1:0] st);
    return V(1'b1, OP_I, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, ctl, st, 1'b0, 1'b0);
  endfunction

  function automatic exp_t observed();
    return {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE, PIPE_FREEZE, HALTED,
            STATE, STALL_CNT, FLUSH_CNT};
  endfunction

  // Drive one vector's inputs and record what the DUT must show for it.
  task automatic drive(input vec_t v);
    sb.push_back('{ctl:v.ctl, st:v.st, sc:m_sc, fc:m_fc});
    rst_n = v.rstn; OPCODE_ID = v.op; RS1_ID = v.rs1; RS2_ID = v.rs2; RD_EX = v.rd;
    MemRead_EX = v.mr; BRANCH_TAKEN_EX = v.br; MEM_BUSY = v.mb;
    #2;
  endtask

  // Advance the counter model across the coming rising edge, then wait for it.
  task automatic advance(input vec_t v);
    if (!v.rstn) begin
      m_sc = 16'd0;
      m_fc = 16'd0;
    end else begin
      if (v.sev && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      if (v.fev && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    vec_t vs[$];
    exp_t e, o;
    vs.push_back(V(1'b0, OP_I, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN, 2'd0, 1'b0, 1'b0));
    vs.push_back(V(1'b0, OP_SYS, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, C_BUSY, 2'd0, 1'b0, 1'b0));
    vs.push_back(IDLE(C_RUN, 2'd0));
    foreach (vs[i]) begin
      drive(vs[i]);
      e = sb.pop_front(); o = observed(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset[%0d] got ctl=%b st=%0d stall=%0d flush=%0d, want ctl=%b st=%0d stall=%0d flush=%0d",
                 i, o.ctl, o.st, o.sc, o.fc, e.ctl, e.st, e.sc, e.fc);
      end
      advance(vs[i]);
    end
  endtask

  task automatic test_load_use();
    vec_t vs[$];
    exp_t e, o;
    vs.push_back(V(1'b1, OP_R,   5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, C_BUB, 2'd0, 1'b1, 1'b0));
    vs.push_back(IDLE(C_RUN, 2'd0));
    vs.push_back(V(1'b1, OP_R,   5'd1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, C_RUN, 2'd0, 1'b0, 1'b0));
    vs.push_back(V(1'b1, OP_LUI, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, C_RUN, 2'd0, 1'b0, 1'b0));
    vs.push_back(V(1'b1, OP_I,   5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, C_RUN, 2'd0, 1'b0, 1'b0));
    vs.push_back(V(1'b1, OP_S,   5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, C_BUB, 2'd0, 1'b1, 1'b0));
    vs.push_back(V(1'b1, OP_S,   5'd5, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, C_RUN, 2'd0, 1'b0, 1'b0));
    vs.push_back(IDLE(C_RUN, 2'd0));
    foreach (vs[i]) begin
      drive(vs[i]);
      e = sb.pop_front(); o = observed(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL load_use[%0d] got ctl=%b st=%0d stall=%0d flush=%0d, want ctl=%b st=%0d stall=%0d flush=%0d",
                 i, o.ctl, o.st, o.sc, o.fc, e.ctl, e.st, e.sc, e.fc);
      end
      advance(vs[i]);
    end
  endtask

  task automatic test_branch_and_busy();
    vec_t vs[$];
    exp_t e, o;
    // Taken branch beats load-use and SYSTEM; MEM_BUSY beats everything.
    vs.push_back(V(1'b1, OP_R,   5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, C_BR,   2'd0, 1'b0, 1'b1));
    vs.push_back(V(1'b1, OP_SYS, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, C_BR,   2'd0, 1'b0, 1'b1));
    vs.push_back(V(1'b1, OP_R,   5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, C_BUSY, 2'd0, 1'b1, 1'b0));
    vs.push_back(V(1'b1, OP_SYS, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, C_BUSY, 2'd0, 1'b1, 1'b0));
    vs.push_back(IDLE(C_RUN, 2'd0));
    foreach (vs[i]) begin
      drive(vs[i]);
      e = sb.pop_front(); o = observed(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL branch_busy[%0d] got ctl=%b st=%0d stall=%0d flush=%0d, want ctl=%b st=%0d stall=%0d flush=%0d",
                 i, o.ctl, o.st, o.sc, o.fc, e.ctl, e.st, e.sc, e.fc);
      end
      advance(vs[i]);
    end
  endtask

  task automatic test_drain_halt();
    vec_t vs[$];
    exp_t e, o;
    vs.push_back(V(1'b1, OP_SYS, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, C_BUB,  2'd0, 1'b0, 1'b0));
    vs.push_back(V(1'b1, OP_R,   5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, C_BUB,  2'd1, 1'b0, 1'b0));
    vs.push_back(IDLE(C_BUB, 2'd1));
    vs.push_back(IDLE(C_BUB, 2'd1));
    vs.push_back(IDLE(C_HALT, 2'd2));
    vs.push_back(V(1'b1, OP_R,   5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, C_HALT, 2'd2, 1'b0, 1'b0));
    vs.push_back(V(1'b0, OP_I,   5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, C_HALT, 2'd2, 1'b0, 1'b0));
    vs.push_back(IDLE(C_RUN, 2'd0));
    foreach (vs[i]) begin
      drive(vs[i]);
      e = sb.pop_front(); o = observed(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL drain_halt[%0d] got ctl=%b st=%0d stall=%0d flush=%0d, want ctl=%b st=%0d stall=%0d flush=%0d",
                 i, o.ctl, o.st, o.sc, o.fc, e.ctl, e.st, e.sc, e.fc);
      end
      advance(vs[i]);
    end
  endtask

  task automatic test_drain_busy();
    vec_t vs[$];
    exp_t e, o;
    vs.push_back(V(1'b1, OP_SYS, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, C_BUB,  2'd0, 1'b0, 1'b0));
    vs.push_back(IDLE(C_BUB, 2'd1));
    vs.push_back(V(1'b1, OP_I,   5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, C_BUSY, 2'd1, 1'b1, 1'b0));
    vs.push_back(V(1'b1, OP_I,   5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, C_BUSY, 2'd1, 1'b1, 1'b0));
    vs.push_back(IDLE(C_BUB, 2'd1));
    vs.push_back(IDLE(C_BUB, 2'd1));
    vs.push_back(IDLE(C_HALT, 2'd2));
    vs.push_back(V(1'b1, OP_I,   5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, C_HALT, 2'd2, 1'b0, 1'b0));
    vs.push_back(V(1'b0, OP_I,   5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, C_HALT, 2'd2, 1'b0, 1'b0));
    vs.push_back(IDLE(C_RUN, 2'd0));
    foreach (vs[i]) begin
      drive(vs[i]);
      e = sb.pop_front(); o = observed(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL drain_busy[%0d] got ctl=%b st=%0d stall=%0d flush=%0d, want ctl=%b st=%0d stall=%0d flush=%0d",
                 i, o.ctl, o.st, o.sc, o.fc, e.ctl, e.st, e.sc, e.fc);
      end
      advance(vs[i]);
    end
  endtask

  task automatic test_stall_saturation();
    vec_t v;
    exp_t e, o;
    int   bad = 0;
    for (int i = 0; i < 70002; i++) begin
      if (i == 70001) v = IDLE(C_RUN, 2'd0);
      else            v = V(1'b1, OP_I, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, C_BUSY, 2'd0, 1'b1, 1'b0);
      drive(v);
      e = sb.pop_front(); o = observed(); vectors++;
      if (o !== e) begin
        miscompares++;
        bad++;
        if (bad <= 5)
          $display("FAIL stall_sat[%0d] got ctl=%b st=%0d stall=%0d flush=%0d, want ctl=%b st=%0d stall=%0d flush=%0d",
                   i, o.ctl, o.st, o.sc, o.fc, e.ctl, e.st, e.sc, e.fc);
      end
      advance(v);
    end
    vectors++;
    if (STALL_CNT !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL stall_sat_final got %h want ffff", STALL_CNT);
    end
  endtask

  initial begin
    rst_n = 1'b0; OPCODE_ID = OP_I; RS1_ID = 5'd1; RS2_ID = 5'd2; RD_EX = 5'd0;
    MemRead_EX = 1'b0; BRANCH_TAKEN_EX = 1'b0; MEM_BUSY = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_load_use();
    test_branch_and_busy();
    test_drain_halt();
    test_drain_busy();
    test_stall_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
